// File: rtl/greenstyle_lfsr_pkg.sv
// Shared definitions for the LFSR pattern generator and PRBS checker:
// mode encodings, per-mode order and tap masks, checker FSM states.
package greenstyle_lfsr_pkg;

  localparam logic [1:0] MODE_PRBS7  = 2'b00;
  localparam logic [1:0] MODE_PRBS9  = 2'b01;
  localparam logic [1:0] MODE_PRBS15 = 2'b10;
  localparam logic [1:0] MODE_LFSR8  = 2'b11;

  // Tap masks over the history register s[14:0] (s[0] = newest bit).
  localparam logic [14:0] TAPS_PRBS7  = 15'h0060;  // s[6]^s[5]
  localparam logic [14:0] TAPS_PRBS9  = 15'h0110;  // s[8]^s[4]
  localparam logic [14:0] TAPS_PRBS15 = 15'h6000;  // s[14]^s[13]
  localparam logic [14:0] TAPS_LFSR8  = 15'h00B8;  // s[7]^s[5]^s[4]^s[3]

  localparam logic [3:0] ORDER_PRBS7  = 4'd7;
  localparam logic [3:0] ORDER_PRBS9  = 4'd9;
  localparam logic [3:0] ORDER_PRBS15 = 4'd15;
  localparam logic [3:0] ORDER_LFSR8  = 4'd8;

  // Consecutive verifying matches needed to declare lock.
  localparam logic [4:0] LOCK_MATCHES = 5'd16;
  // Consecutive misses in lock that drop back to seeding.
  localparam int unsigned LOSS_MISSES = 4;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } chk_state_e;

  function automatic logic [14:0] mode_taps(input logic [1:0] m);
    logic [14:0] t;
    unique case (m)
      MODE_PRBS7:  t = TAPS_PRBS7;
      MODE_PRBS9:  t = TAPS_PRBS9;
      MODE_PRBS15: t = TAPS_PRBS15;
      default:     t = TAPS_LFSR8;
    endcase
    return t;
  endfunction

  function automatic logic [3:0] mode_order(input logic [1:0] m);
    logic [3:0] o;
    unique case (m)
      MODE_PRBS7:  o = ORDER_PRBS7;
      MODE_PRBS9:  o = ORDER_PRBS9;
      MODE_PRBS15: o = ORDER_PRBS15;
      default:     o = ORDER_LFSR8;
    endcase
    return o;
  endfunction

  // Mask selecting the low 'ord' bits of the history register.
  function automatic logic [14:0] order_mask(input logic [3:0] ord);
    logic [15:0] m;
    m = (16'd1 << ord) - 16'd1;
    return m[14:0];
  endfunction

endpackage

// File: rtl/greenstyle_lfsr_predict.sv
// Combinational next-bit predictor: XOR of the mode's taps over the
// history register, plus the mode's register order.
module greenstyle_lfsr_predict
  import greenstyle_lfsr_pkg::*;
(
  input  logic [14:0] s,
  input  logic [1:0]  mode,
  output logic        p,
  output logic [3:0]  order
);

  // Prediction and order lookup for the selected polynomial.
  always_comb begin
    p     = ^(s & mode_taps(mode));
    order = mode_order(mode);
  end

endmodule

// File: rtl/greenstyle_prbs_checker.sv
// Serial PRBS checker: seeds from the incoming stream, verifies 16
// predictions before declaring lock, then counts bit errors while
// shifting in predicted bits so single errors do not propagate.
module greenstyle_prbs_checker
  import greenstyle_lfsr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       data_in,
  input  logic       in_valid,
  input  logic       clr,
  output logic       locked,
  output logic       bit_err,
  output logic [7:0] err_count
);

  localparam logic [1:0] LAST_MISS = 2'(LOSS_MISSES - 1);

  chk_state_e  state_q, state_d;
  logic [14:0] s_q, s_d;
  logic [3:0]  seed_cnt_q, seed_cnt_d;
  logic [4:0]  match_cnt_q, match_cnt_d;
  logic [1:0]  miss_cnt_q, miss_cnt_d;
  logic [7:0]  err_cnt_d;
  logic        bit_err_d;
  logic [1:0]  mode_q;

  logic        p;
  logic [3:0]  order;
  logic [14:0] s_shift;
  logic [3:0]  seed_cnt_inc;
  logic [4:0]  match_cnt_inc;
  logic        miss;

  greenstyle_lfsr_predict u_predict (
    .s     (s_q),
    .mode  (mode),
    .p     (p),
    .order (order)
  );

  // Next-state logic for the seed/verify/lock FSM, history and counters.
  always_comb begin
    state_d       = state_q;
    s_d           = s_q;
    seed_cnt_d    = seed_cnt_q;
    match_cnt_d   = match_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    err_cnt_d     = err_count;
    bit_err_d     = 1'b0;
    s_shift       = {s_q[13:0], data_in};
    seed_cnt_inc  = seed_cnt_q + 4'd1;
    match_cnt_inc = match_cnt_q + 5'd1;
    miss          = data_in ^ p;

    if (mode != mode_q) begin
      state_d     = ST_SEED;
      s_d         = '0;
      seed_cnt_d  = '0;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      err_cnt_d   = '0;
    end else if (in_valid) begin
      unique case (state_q)
        ST_SEED: begin
          s_d        = s_shift;
          seed_cnt_d = seed_cnt_inc;
          if (seed_cnt_inc == order) begin
            seed_cnt_d = '0;
            // An all-zero seed is the LFSR lock-up state; keep seeding.
            if ((s_shift & order_mask(order)) != '0) begin
              state_d     = ST_VERIFY;
              match_cnt_d = '0;
            end
          end
        end
        ST_VERIFY: begin
          s_d = s_shift;
          if (miss) begin
            state_d     = ST_SEED;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end else if (match_cnt_inc == LOCK_MATCHES) begin
            state_d     = ST_LOCK;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
          end else begin
            match_cnt_d = match_cnt_inc;
          end
        end
        ST_LOCK: begin
          s_d = {s_q[13:0], p};
          if (miss) begin
            bit_err_d = 1'b1;
            if (err_count != 8'hFF) err_cnt_d = err_count + 8'd1;
            if (miss_cnt_q == LAST_MISS) begin
              state_d     = ST_SEED;
              seed_cnt_d  = '0;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 2'd1;
            end
          end else begin
            miss_cnt_d = '0;
          end
        end
        default: begin
          state_d     = ST_SEED;
          seed_cnt_d  = '0;
          match_cnt_d = '0;
          miss_cnt_d  = '0;
        end
      endcase
    end

    if (clr) begin
      err_cnt_d = '0;
      bit_err_d = 1'b0;
    end
  end

  // State, history, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SEED;
      s_q         <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      mode_q      <= MODE_PRBS7;
      err_count   <= '0;
      bit_err     <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      mode_q      <= mode;
      err_count   <= err_cnt_d;
      bit_err     <= bit_err_d;
      locked      <= (state_d == ST_LOCK);
    end
  end

endmodule
